// File: rtl/conv_pkg.sv
// Shared constants, load-FSM state encoding and the output narrowing helper
// used by the 3x3 convolution engine.
package conv_pkg;

  localparam int TAPS       = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } ld_state_e;

  // Arithmetic shift (floor) then clamp to the signed data_w range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int frac_w,
                                                   input int data_w);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/conv3x3_engine_mac9.sv
// One input channel of the 3x3 convolution: nine registered products followed
// by a registered nine-way sum. Both stages hold while en is low.
module conv_mac9 import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [TAPS*DATA_W-1:0]       win,
  input  logic [TAPS*DATA_W-1:0]       wts,
  output logic signed [2*DATA_W+3:0]   sum_p1
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 4;

  logic signed [PROD_W-1:0] prod_p0 [TAPS];
  logic signed [SUM_W-1:0]  sum_c;

  // Stage 1: products
  always_ff @(posedge clk) begin
    if (en) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_p0[t] <= $signed(win[t*DATA_W +: DATA_W]) * $signed(wts[t*DATA_W +: DATA_W]);
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int t = 0; t < TAPS; t++) begin
      sum_c += SUM_W'(prod_p0[t]);
    end
  end

  // Stage 2: per-channel sum
  always_ff @(posedge clk) begin
    if (en) sum_p1 <= sum_c;
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Multi-channel 3x3 convolution core: weight-load FSM and register file,
// CH per-channel MACs, cross-channel reduction with floor-shift/saturation.
module conv3x3_engine import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH     = 3,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ADDR_W = 9
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        wt_load,
  output logic                        wt_rd_en,
  output logic [ADDR_W-1:0]           wt_addr,
  input  logic signed [DATA_W-1:0]    wt_rdata,
  output logic                        wt_ready,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W*TAPS*CH-1:0]   in_win,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_data
);

  localparam int N     = CH * TAPS;
  localparam int SUM_W = 2 * DATA_W + 4;
  localparam int ACC_W = SUM_W + $clog2(CH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  ld_state_e                state;
  logic                     wr_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic signed [DATA_W-1:0] wt_q [N];
  logic [N*DATA_W-1:0]      wt_flat;

  logic                     vld_p0, vld_p1, vld_p2;
  logic                     stall, adv;
  logic signed [SUM_W-1:0]  csum_p1 [CH];
  logic signed [ACC_W-1:0]  tot_c;

  assign wt_ready  = (state == READY);
  assign out_valid = vld_p2;
  assign stall     = vld_p2 && !out_ready;
  assign adv       = !stall;
  assign in_ready  = wt_ready && adv;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      wt_rd_en  <= 1'b0;
      wt_addr   <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      // RAM data trails the address by one cycle
      wr_q      <= wt_rd_en;
      wr_addr_q <= wt_addr;
      case (state)
        IDLE, READY: begin
          if (wt_load) begin
            state    <= LOAD;
            wt_rd_en <= 1'b1;
            wt_addr  <= '0;
          end
        end
        LOAD: begin
          if (wt_addr == LAST_ADDR) begin
            state    <= DRAIN;
            wt_rd_en <= 1'b0;
            wt_addr  <= '0;
          end else begin
            wt_addr <= wt_addr + 1'b1;
          end
        end
        DRAIN:   state <= READY;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int a = 0; a < N; a++) wt_q[a] <= '0;
    end else if (wr_q) begin
      for (int a = 0; a < N; a++) begin
        if (wr_addr_q == ADDR_W'(a)) wt_q[a] <= wt_rdata;
      end
    end
  end

  for (genvar a = 0; a < N; a++) begin : g_flat
    assign wt_flat[a*DATA_W +: DATA_W] = wt_q[a];
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid && wt_ready;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    conv_mac9 #(.DATA_W(DATA_W)) u_mac (
      .clk    (clk),
      .en     (adv),
      .win    (in_win [c*TAPS*DATA_W +: TAPS*DATA_W]),
      .wts    (wt_flat[c*TAPS*DATA_W +: TAPS*DATA_W]),
      .sum_p1 (csum_p1[c])
    );
  end

  always_comb begin
    tot_c = '0;
    for (int c = 0; c < CH; c++) begin
      tot_c += ACC_W'(csum_p1[c]);
    end
  end

  // Stage 3: cross-channel sum, shift, saturate
  always_ff @(posedge clk) begin
    if (RESET) begin
      out_data <= '0;
    end else if (adv && vld_p1) begin
      out_data <= DATA_W'(sat_shift(64'(tot_c), FRAC_W, DATA_W));
    end
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Parametrised multi-channel 3x3 convolution engine. Loads `CH*9` signed weights from an external synchronous-read weight RAM into internal registers, then accepts one 3x3xCH input window per cycle. Each window is reduced to a single saturated fixed-point output through a 3-stage pipeline with valid/ready backpressure. It is the per-output-pixel compute core between the window line-buffer and the activation/pooling stage.

## Interface
- `DATA_W`, 16: signed two's-complement width of inputs, weights and output.
- `CH`, 3: input channel count (1..16).
- `FRAC_W`, 8: fractional bits of the fixed-point format (Q(DATA_W-FRAC_W).FRAC_W).
- `ADDR_W`, 9: weight RAM address width; must satisfy 2^ADDR_W >= CH*9.

- `clk`  in  1  clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `wt_load`  in  1  start or restart a weight load; single-cycle pulse.
- `wt_rd_en`  out  1  weight RAM read enable.
- `wt_addr`  out  ADDR_W  weight RAM read address.
- `wt_rdata`  in  DATA_W  weight RAM data; valid one cycle after `wt_rd_en`.
- `wt_ready`  out  1  full weight set resident; compute permitted.
- `in_valid`  in  1  input window valid.
- `in_ready`  out  1  engine accepts window this cycle.
- `in_win`  in  DATA_W*9*CH  channel c, tap t (t = row*3+col) at bits [(c*9+t)*DATA_W +: DATA_W].
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  DATA_W  saturated convolution result.

## Operation
- Weight address `a = c*9 + t`, matching the `in_win` lane ordering.
- Load FSM has four states:
  - IDLE: wait for `wt_load`.
  - LOAD: issue one address per cycle, 0..CH*9-1.
  - DRAIN: capture the last returned word.
  - READY: `wt_ready`=1.
- Transitions: IDLE/READY --wt_load--> LOAD; LOAD --last address--> DRAIN; DRAIN --> READY.
- The word at `wt_rdata` in the cycle after address a is issued is written to weight register a.
- `wt_load` during LOAD or DRAIN is ignored.
- `wt_load` in READY drops `wt_ready` on the next cycle and reloads.
- `in_ready = wt_ready && !stall`, where `stall = out_valid && !out_ready`.
- A window is accepted when `in_valid && in_ready`.
- Stage 1: CH*9 signed products, each 2*DATA_W bits, using the weights present at acceptance.
- Stage 2: per-channel 9-product sums, 2*DATA_W+4 bits.
- Stage 3: cross-channel sum (2*DATA_W+4+clog2(CH) bits), arithmetic right shift by FRAC_W (truncation toward -inf), then saturation.
- Saturation range: [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- On stall, all three stages hold and `out_data` is stable.
- Beats already in flight complete with the weights latched in their products. A reload never corrupts them.

## Timing
- Reset values: `wt_rd_en`=0, `wt_addr`=0, `wt_ready`=0, `in_ready`=0, `out_valid`=0, `out_data`=0. FSM goes to IDLE, weights are cleared to 0, pipeline valids are cleared.
- Load sequence, with N = CH*9 and `wt_load` sampled at cycle 0:
  - Cycles 1..N: `wt_rd_en`=1, `wt_addr`=0..N-1.
  - Cycles 2..N+1: weight writes.
  - Cycle N+1: DRAIN.
  - Cycle N+2 onward: `wt_ready`=1.
  - Example: CH=3 gives `wt_ready` at cycle 29.
- Latency: a window accepted at cycle k produces `out_valid` at k+3 when there is no stall. Throughput is 1 window per cycle.
- A window accepted in the same cycle that `wt_load` is sampled uses the old weights.
- RESET mid-load or mid-stream aborts everything. In-flight results are discarded and weights are cleared; `wt_load` is required again.
- Simultaneous `RESET` and `wt_load`: RESET wins.

## Structure
- Shared package `conv_pkg`:
  - constant `TAPS`=9;
  - default `DATA_W`/`FRAC_W`;
  - FSM state enum {IDLE, LOAD, DRAIN, READY};
  - saturating narrow function `sat_shift(acc, FRAC_W, DATA_W)`.
- Sub-module `conv_mac9`: one channel; 9 multiplies registered, then a registered 9-input sum (stages 1–2). It is instantiated CH times by generate.
- The top level holds the load FSM, the weight register file, stage 3 and the valid/stall control.

## Test plan
- Load and unit conv (CH=3, FRAC_W=8): all weights 0x0100, all window taps 0x0100 → `out_data`=0x1B00 (27.0) at accept+3, with `wt_ready` asserted at cycle 29 after `wt_load`.
- Lane ordering: weight RAM[a]=a (raw integer), window lane c*9+t = 0x0100 only at c=2,t=4, others 0 → `out_data`=22 (0x0016).
- Saturation: all weights and taps 0x7FFF → 0x7FFF; weights 0x8000 with taps 0x7FFF → 0x8000.
- Backpressure: stream 10 windows with `out_ready` toggled 1,0,0,1 → all 10 results delivered in order, none lost or duplicated, and `out_data` stable while stalled.
- Reload mid-stream: `wt_load` with 3 beats in flight → those 3 results use the old weights; `in_ready`=0 until the new set is READY; the next beat uses the new weights.
- RESET at load cycle 10 → outputs return to reset values next cycle, `wt_ready` stays 0, and a subsequent `wt_load` completes normally.
